load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Parametrised, handshaked load-alignment engine between the CPU datapath and the data-memory read port.
- Accepts one load op per request, issues word-aligned memory reads and extracts the addressed bytes (big-endian).
- Produces the register write-back value: LB/LBU/LH/LHU sign/zero extension, plus LWL/LWR partial-word merge with the old rt value.
- Generalises the earlier combinational LWL/LWR merge to DATA_W-wide words, with misalignment detection and an optional two-read split for word-crossing loads.

Parameters:
DATA_W  32  word width in bits; multiple of 8, >= 32; B = DATA_W/8 byte lanes
ADDR_W  32  byte-address width
TAG_W   4   opaque request tag returned with the response

Ports:
clk             in   1       clock, rising edge
rst_n           in   1       asynchronous active-low reset
req_valid       in   1       load request valid
req_ready       out  1       unit can accept a request
req_op          in   3       000 LB, 001 LH, 010 LWL, 011 LW, 100 LBU, 101 LHU, 110 LWR, 111 reserved
req_addr        in   ADDR_W  byte address
req_rt          in   DATA_W  current rt value (used by LWL/LWR)
req_tag         in   TAG_W   request tag
mem_rd_valid    out  1       memory read request valid
mem_rd_ready    in   1       memory accepts read request
mem_rd_addr     out  ADDR_W  word-aligned read address (low log2(B) bits zero)
mem_resp_valid  in   1       read data valid; one response per accepted read, in order
mem_resp_data   in   DATA_W  read data, byte 0 in bits [DATA_W-1 -: 8]
rsp_valid       out  1       result valid
rsp_ready       in   1       consumer accepts result
rsp_data        out  DATA_W  write-back value
rsp_tag         out  TAG_W   tag of the request
rsp_err         out  1       address/op error; rsp_data = 0 when set

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state IDLE. req_ready=1; mem_rd_valid, rsp_valid, rsp_err = 0; mem_rd_addr, rsp_data, rsp_tag = 0.
- FSM states: IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP. req_ready=1 only in IDLE. mem_rd_valid=1 only in ISSUE/ISSUE2.
- IDLE: on req_valid, capture op/addr/rt/tag.
  - Reserved op, or misaligned access -> RESP with rsp_err=1, no memory read.
  - Misaligned means: LH/LHU with addr[0]=1; LW with addr[log2(B)-1:0] != 0. LB/LBU/LWL/LWR are never misaligned.
  - Otherwise -> ISSUE.
- ISSUE: mem_rd_addr = addr with low bits cleared; hold until mem_rd_ready, then -> WAIT. mem_rd_valid/addr stay stable while stalled.
- WAIT: on mem_resp_valid, register the computed result -> RESP. mem_resp_valid in any other state is ignored.
- RESP: rsp_valid=1; data/tag/err held stable until rsp_ready, then -> IDLE. The next request is accepted no earlier than the following cycle.
- Latency: with mem_rd_ready=1 and response the cycle after issue, rsp_valid rises 3 cycles after the accept edge. Error responses appear 1 cycle after the accept edge.
- Result formulas (k = byte offset, W = mem_resp_data, s = B-1-k):
  - LB/LBU: byte = W >> 8s; sign- or zero-extended to DATA_W.
  - LH/LHU: half = W >> 8(s-1); sign- or zero-extended to DATA_W.
  - LW: W.
  - LWL: (W << 8k) | (rt & ((1<<8k)-1)).
  - LWR: (W >> 8s) | (rt & ~(ALL_ONES >> 8s)).
- Reset mid-operation: immediate return to IDLE with reset outputs; any in-flight memory response is dropped.

Optional Feature:
- Macro: LOAD_ALIGN_UNALIGNED_SPLIT_EN.
- Defined:
  - Misaligned LH/LHU/LW do not error.
  - If the access fits in one word: single read, bytes extracted from offset k.
  - If it crosses a word boundary: ISSUE/WAIT reads word A, then ISSUE2/WAIT2 reads A+B.
  - Result bytes are the concatenation of the upper lanes of word A and the lower lanes of word A+B; rsp_valid rises after the second response.
- Undefined: ISSUE2/WAIT2 are absent; misaligned requests return rsp_err=1.

Test Plan:
- Memory 0x100 = 0x11223344; LWL addr 0x101, rt=0xAABBCCDD -> rsp_data 0x223344DD, one read at 0x100, rsp_err 0.
- Same memory; LWR addr 0x101, rt=0xAABBCCDD -> 0xAABB1122; LWR addr 0x103 -> 0x11223344.
- Memory 0x100 = 0x112233F4; LB addr 0x103 -> 0xFFFFFFF4; LBU -> 0x000000F4; LH addr 0x102 -> 0x000033F4.
- LW addr 0x102:
  - Macro undefined: rsp_err=1, data 0, mem_rd_valid never asserted, response 1 cycle after accept.
  - Macro defined, 0x104 = 0x55667788: reads at 0x100 then 0x104 -> 0x33445566.
  - Op 111 at any address: rsp_err=1.
- Back-pressure: mem_rd_ready low 4 cycles, then rsp_ready low 5 cycles -> mem_rd_addr, rsp_data and rsp_tag stable throughout; req_ready=0 until the rsp handshake.
- rst_n pulsed low in WAIT -> all outputs zero, req_ready=1 asynchronously; a late mem_resp_valid is ignored; the next LW at 0x100 returns 0x11223344.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: handshaked load-alignment engine between the CPU datapath and
// a word-wide data-memory read port. Extracts big-endian bytes for LB/LBU/LH/LHU/LW
// and merges partial words with the old rt value for LWL/LWR.
// Optional macro LOAD_ALIGN_UNALIGNED_SPLIT_EN: misaligned LH/LHU/LW are serviced
// (with a second word read when they cross a word boundary) instead of erroring.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_rt,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);
  localparam int SH_W  = OFF_W + 3;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LWL = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LWR = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
`ifdef LOAD_ALIGN_UNALIGNED_SPLIT_EN
    S_ISSUE2 = 3'd3,
    S_WAIT2  = 3'd4,
`endif
    S_RESP   = 3'd5
  } state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic [OFF_W-1:0]    r_off;
  logic [DATA_W-1:0]   r_rt;
  logic [TAG_W-1:0]    r_tag;
  logic                r_req_ready;
  logic                r_mem_rd_valid;
  logic [ADDR_W-1:0]   r_mem_rd_addr;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [TAG_W-1:0]    r_rsp_tag;
  logic                r_rsp_err;
`ifdef LOAD_ALIGN_UNALIGNED_SPLIT_EN
  logic [DATA_W-1:0]   r_word_a;
  logic                w_cross;
`endif

  logic                w_req_err;
  logic [SH_W-1:0]     w_sh_k;
  logic [SH_W-1:0]     w_sh_s;
  logic [DATA_W-1:0]   w_hi;
  logic [DATA_W-1:0]   w_lo;
  logic [2*DATA_W-1:0] w_pair_shl;
  logic [DATA_W-1:0]   w_top;
  logic                w_sign;
  logic [DATA_W-1:0]   w_result;

  assign req_ready    = r_req_ready;
  assign mem_rd_valid = r_mem_rd_valid;
  assign mem_rd_addr  = r_mem_rd_addr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_tag      = r_rsp_tag;
  assign rsp_err      = r_rsp_err;

  // Shift amounts: 8*k moves byte k to the top lane, 8*s moves byte 0 to lane k.
  assign w_sh_k = {r_off, 3'b000};
  assign w_sh_s = {OFF_W'(B - 1) - r_off, 3'b000};

  // The addressed bytes always live in the upper lanes of {first word, second word}
  // once shifted left by 8*k; single-word accesses use zero as the second word.
`ifdef LOAD_ALIGN_UNALIGNED_SPLIT_EN
  assign w_hi = (r_state == S_WAIT2) ? r_word_a : mem_resp_data;
  assign w_lo = (r_state == S_WAIT2) ? mem_resp_data : '0;
`else
  assign w_hi = mem_resp_data;
  assign w_lo = '0;
`endif
  assign w_pair_shl = {w_hi, w_lo} << w_sh_k;
  assign w_top      = w_pair_shl[2*DATA_W-1 -: DATA_W];
  assign w_sign     = ~r_op[2];

  // Build the write-back value from the aligned top lanes (or the raw word for LWR).
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_LB, OP_LBU: w_result = {{(DATA_W-8){w_sign & w_top[DATA_W-1]}}, w_top[DATA_W-1 -: 8]};
      OP_LH, OP_LHU: w_result = {{(DATA_W-16){w_sign & w_top[DATA_W-1]}}, w_top[DATA_W-1 -: 16]};
      OP_LW:         w_result = w_top;
      OP_LWL:        w_result = w_top | (r_rt & ~({DATA_W{1'b1}} << w_sh_k));
      OP_LWR:        w_result = (mem_resp_data >> w_sh_s) | (r_rt & ~({DATA_W{1'b1}} >> w_sh_s));
      default:       w_result = '0;
    endcase
  end

  // Reject reserved ops and, without split support, misaligned halfword/word loads.
  always_comb begin
    w_req_err = (req_op == OP_RSV);
`ifndef LOAD_ALIGN_UNALIGNED_SPLIT_EN
    if ((req_op == OP_LH || req_op == OP_LHU) && req_addr[0])
      w_req_err = 1'b1;
    if (req_op == OP_LW && req_addr[OFF_W-1:0] != '0)
      w_req_err = 1'b1;
`endif
  end

`ifdef LOAD_ALIGN_UNALIGNED_SPLIT_EN
  // An access crosses into the next word when its last byte lies beyond lane B-1.
  always_comb begin
    w_cross = 1'b0;
    if (r_op == OP_LH || r_op == OP_LHU)
      w_cross = (r_off == OFF_W'(B - 1));
    else if (r_op == OP_LW)
      w_cross = (r_off != '0);
  end
`endif

  // Request / memory / response sequencing with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_off          <= '0;
      r_rt           <= '0;
      r_tag          <= '0;
      r_req_ready    <= 1'b1;
      r_mem_rd_valid <= 1'b0;
      r_mem_rd_addr  <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_tag      <= '0;
      r_rsp_err      <= 1'b0;
`ifdef LOAD_ALIGN_UNALIGNED_SPLIT_EN
      r_word_a       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_off       <= req_addr[OFF_W-1:0];
            r_rt        <= req_rt;
            r_tag       <= req_tag;
            r_req_ready <= 1'b0;
            if (w_req_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_tag   <= req_tag;
              r_state     <= S_RESP;
            end else begin
              r_mem_rd_valid <= 1'b1;
              r_mem_rd_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              r_state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_rd_ready) begin
            r_mem_rd_valid <= 1'b0;
            r_state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
`ifdef LOAD_ALIGN_UNALIGNED_SPLIT_EN
            if (w_cross) begin
              r_word_a       <= mem_resp_data;
              r_mem_rd_valid <= 1'b1;
              r_mem_rd_addr  <= r_mem_rd_addr + ADDR_W'(B);
              r_state        <= S_ISSUE2;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_data  <= w_result;
              r_rsp_tag   <= r_tag;
              r_state     <= S_RESP;
            end
`else
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= w_result;
            r_rsp_tag   <= r_tag;
            r_state     <= S_RESP;
`endif
          end
        end
`ifdef LOAD_ALIGN_UNALIGNED_SPLIT_EN
        S_ISSUE2: begin
          if (mem_rd_ready) begin
            r_mem_rd_valid <= 1'b0;
            r_state        <= S_WAIT2;
          end
        end
        S_WAIT2: begin
          if (mem_resp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= w_result;
            r_rsp_tag   <= r_tag;
            r_state     <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_mem_rd_valid <= 1'b0;
          r_rsp_valid    <= 1'b0;
          r_req_ready    <= 1'b1;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Testbench for load_align_unit (DATA_W=32). Works with or without
// LOAD_ALIGN_UNALIGNED_SPLIT_EN; expectations follow the macro.
`timescale 1ns/1ps
module tb_load_align_unit;

`ifdef LOAD_ALIGN_UNALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_rt = '0;
  logic [3:0]  req_tag = '0;
  logic        mem_rd_valid;
  logic        mem_rd_ready = 1'b0;
  logic [31:0] mem_rd_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_rt(req_rt), .req_tag(req_tag),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // Memory: 64 words, aliased on address bits [7:2]
  logic [31:0] mem_words [0:63];
  int          rd_stall = 0;
  int          resp_delay = 0;
  logic [31:0] rd_log [$];
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          stalled = 1'b0;
  logic [31:0] stall_addr = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_words[a[7:2]];
    return 8'(w >> (8 * (3 - int'(a[1:0]))));
  endfunction

  // Memory responder: accepts reads (optionally stalled), answers after resp_delay
  always @(negedge clk) begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = $urandom;
    if (pend) begin
      if (pend_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_words[pend_addr[7:2]];
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (stalled) chk("rd_valid_held", {31'd0, mem_rd_valid}, 32'd1);
    if (mem_rd_valid) begin
      if (stalled) chk("rd_addr_stable", mem_rd_addr, stall_addr);
      if (rd_stall > 0) begin
        mem_rd_ready = 1'b0;
        rd_stall--;
        stalled    = 1'b1;
        stall_addr = mem_rd_addr;
      end else begin
        mem_rd_ready = 1'b1;
        stalled   = 1'b0;
        pend      = 1'b1;
        pend_cnt  = resp_delay;
        pend_addr = mem_rd_addr;
        rd_log.push_back(mem_rd_addr);
      end
    end else begin
      mem_rd_ready = 1'b0;
      stalled = 1'b0;
    end
  end

  // Reference model: byte-wise big-endian memory view
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rt,
                       output logic [31:0] d, output logic e, output int nrd);
    int k;
    int n;
    logic [31:0] base;
    k = int'(a[1:0]);
    base = {a[31:2], 2'b00};
    d = '0;
    e = (op == 3'd7);
    nrd = 1;
    case (op)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd3:       n = 4;
      default:    n = 0;
    endcase
    if (!SPLIT) begin
      if ((op == 3'd1 || op == 3'd5) && a[0]) e = 1'b1;
      if (op == 3'd3 && k != 0) e = 1'b1;
    end
    if (e) begin
      nrd = 0;
      d = '0;
    end else if (n > 0) begin
      if (k + n > 4) nrd = 2;
      for (int j = 0; j < n; j++) d = (d << 8) | {24'd0, mem_byte(a + j)};
      if (op == 3'd0 && d[7])  d = d | 32'hFFFFFF00;
      if (op == 3'd1 && d[15]) d = d | 32'hFFFF0000;
    end else if (op == 3'd2) begin
      for (int j = 0; j < 4; j++)
        d[31-8*j -: 8] = (j < 4 - k) ? mem_byte(a + j) : rt[31-8*j -: 8];
    end else begin
      for (int j = 0; j < 4; j++)
        d[31-8*j -: 8] = (j >= 3 - k) ? mem_byte(base + j - (3 - k)) : rt[31-8*j -: 8];
    end
  endtask

  // One full transaction: request, wait for response, optional response back-pressure
  task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input logic [3:0] tag, input int rstall, input int pstall,
                         output logic [31:0] d, output logic e, output int lat);
    logic [31:0] d0;
    logic [3:0]  t0;
    logic        e0;
    rd_log.delete();
    @(negedge clk);
    rd_stall = rstall;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_rt = rt; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_rt = $urandom; req_tag = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    d0 = rsp_data; t0 = rsp_tag; e0 = rsp_err;
    for (int i = 0; i < pstall; i++) begin
      @(negedge clk);
      chk("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_data_stable", rsp_data, d0);
      chk("rsp_tag_stable", {28'd0, rsp_tag}, {28'd0, t0});
      chk("rsp_err_stable", {31'd0, rsp_err}, {31'd0, e0});
      chk("req_ready_rsp", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    d = rsp_data;
    e = rsp_err;
    chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, tag});
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] d;
    logic        e;
    int          nrd;
  } vec_t;

  vec_t vecs [20];

  task automatic check_reads(input string tag, input logic [31:0] a, input int nrd);
    chk({tag, "_nreads"}, rd_log.size(), nrd);
    if (nrd >= 1 && rd_log.size() >= 1) chk({tag, "_rd0"}, rd_log[0], {a[31:2], 2'b00});
    if (nrd >= 2 && rd_log.size() >= 2) chk({tag, "_rd1"}, rd_log[1], {a[31:2], 2'b00} + 32'd4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, ed;
    logic        e, ee;
    int          lat, enrd, elat, rs, ps, rdl;
    logic [2:0]  op;
    logic [31:0] a, rt;

    vecs[0]  = '{3'd2, 32'h101, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h223344DD, 1'b0, 1};
    vecs[1]  = '{3'd6, 32'h101, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hAABB1122, 1'b0, 1};
    vecs[2]  = '{3'd6, 32'h103, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h11223344, 1'b0, 1};
    vecs[3]  = '{3'd0, 32'h103, 32'hAABBCCDD, 32'h112233F4, 32'h55667788, 32'hFFFFFFF4, 1'b0, 1};
    vecs[4]  = '{3'd4, 32'h103, 32'hAABBCCDD, 32'h112233F4, 32'h55667788, 32'h000000F4, 1'b0, 1};
    vecs[5]  = '{3'd1, 32'h102, 32'hAABBCCDD, 32'h112233F4, 32'h55667788, 32'h000033F4, 1'b0, 1};
    vecs[6]  = '{3'd3, 32'h102, 32'hAABBCCDD, 32'h11223344, 32'h55667788,
                 SPLIT ? 32'h33445566 : 32'h0, !SPLIT, SPLIT ? 2 : 0};
    vecs[7]  = '{3'd7, 32'h100, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h0, 1'b1, 0};
    vecs[8]  = '{3'd7, 32'h102, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h0, 1'b1, 0};
    vecs[9]  = '{3'd1, 32'h100, 32'hAABBCCDD, 32'h8899AABB, 32'h55667788, 32'hFFFF8899, 1'b0, 1};
    vecs[10] = '{3'd5, 32'h100, 32'hAABBCCDD, 32'h8899AABB, 32'h55667788, 32'h00008899, 1'b0, 1};
    vecs[11] = '{3'd3, 32'h104, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h55667788, 1'b0, 1};
    vecs[12] = '{3'd0, 32'h100, 32'hAABBCCDD, 32'h8899AABB, 32'h55667788, 32'hFFFFFF88, 1'b0, 1};
    vecs[13] = '{3'd2, 32'h100, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h11223344, 1'b0, 1};
    vecs[14] = '{3'd2, 32'h103, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h44BBCCDD, 1'b0, 1};
    vecs[15] = '{3'd6, 32'h100, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hAABBCC11, 1'b0, 1};
    vecs[16] = '{3'd1, 32'h103, 32'hAABBCCDD, 32'h11223344, 32'h55667788,
                 SPLIT ? 32'h00004455 : 32'h0, !SPLIT, SPLIT ? 2 : 0};
    vecs[17] = '{3'd5, 32'h101, 32'hAABBCCDD, 32'h11223344, 32'h55667788,
                 SPLIT ? 32'h00002233 : 32'h0, !SPLIT, SPLIT ? 1 : 0};
    vecs[18] = '{3'd4, 32'h100, 32'hAABBCCDD, 32'h8899AABB, 32'h55667788, 32'h00000088, 1'b0, 1};
    vecs[19] = '{3'd3, 32'h101, 32'hAABBCCDD, 32'h11223344, 32'h55667788,
                 SPLIT ? 32'h22334455 : 32'h0, !SPLIT, SPLIT ? 2 : 0};

    for (int i = 0; i < 64; i++) mem_words[i] = $urandom;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_rd_valid", {31'd0, mem_rd_valid}, 32'd0);
    chk("rst_mem_rd_addr", mem_rd_addr, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      mem_words[0] = vecs[i].m0;
      mem_words[1] = vecs[i].m1;
      resp_delay = 0;
      do_load(vecs[i].op, vecs[i].addr, vecs[i].rt, 4'(i), 0, 0, d, e, lat);
      elat = vecs[i].e ? 1 : (vecs[i].nrd == 2 ? 5 : 3);
      chk($sformatf("vec%0d_data", i), d, vecs[i].d);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].e});
      chk($sformatf("vec%0d_lat", i), lat, elat);
      check_reads($sformatf("vec%0d", i), vecs[i].addr, vecs[i].nrd);
      $display("vec %0d: op=%0d addr=%08h data=%08h err=%0b lat=%0d reads=%0d",
               i, vecs[i].op, vecs[i].addr, d, e, lat, rd_log.size());
    end

    // Back-pressure: read port stalled 4 cycles, response held 5 cycles
    mem_words[0] = 32'h11223344;
    resp_delay = 0;
    do_load(3'd3, 32'h100, 32'h0, 4'hA, 4, 5, d, e, lat);
    chk("bp_data", d, 32'h11223344);
    chk("bp_err", {31'd0, e}, 32'd0);
    chk("bp_lat", lat, 7);
    check_reads("bp", 32'h100, 1);
    $display("bp: data=%08h err=%0b lat=%0d", d, e, lat);

    // Reset while waiting for the memory response; late response must be ignored
    resp_delay = 4;
    rd_log.delete();
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_addr = 32'h100; req_tag = 4'h5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_reads", rd_log.size(), 1);
    chk("pre_rst_rd_valid", {31'd0, mem_rd_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_mem_rd_valid", {31'd0, mem_rd_valid}, 32'd0);
    chk("arst_mem_rd_addr", mem_rd_addr, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("arst_rsp_data", rsp_data, 32'd0);
    chk("arst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("late_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("late_req_ready", {31'd0, req_ready}, 32'd1);
    end
    resp_delay = 0;
    mem_words[0] = 32'h11223344;
    do_load(3'd3, 32'h100, 32'h0, 4'h3, 0, 0, d, e, lat);
    chk("post_rst_data", d, 32'h11223344);
    chk("post_rst_err", {31'd0, e}, 32'd0);
    $display("post-reset: data=%08h err=%0b lat=%0d", d, e, lat);

    // Randomised traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 32'h100 | 32'($urandom_range(0, 255));
      rt = $urandom;
      mem_words[a[7:2]] = $urandom;
      mem_words[6'(a[7:2] + 6'd1)] = $urandom;
      rs  = $urandom_range(0, 2);
      ps  = $urandom_range(0, 2);
      rdl = $urandom_range(0, 2);
      resp_delay = rdl;
      model(op, a, rt, ed, ee, enrd);
      do_load(op, a, rt, 4'(i), rs, ps, d, e, lat);
      elat = ee ? 1 : (enrd == 2 ? 5 + rs + 2 * rdl : 3 + rs + rdl);
      chk($sformatf("rnd%0d_data", i), d, ed);
      chk($sformatf("rnd%0d_err", i), {31'd0, e}, {31'd0, ee});
      chk($sformatf("rnd%0d_lat", i), lat, elat);
      check_reads($sformatf("rnd%0d", i), a, enrd);
      $display("rnd %0d: op=%0d addr=%08h rt=%08h data=%08h err=%0b lat=%0d",
               i, op, a, rt, d, e, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
